// File: rtl/oldland_bus_arbiter_if.sv
// Oldland data bus handshake bundle (access/ack/error) shared by masters and the slave port.
// The master modport drives the request; the slave modport answers it.
interface oldland_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] bytesel;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wr_val;
    logic                    access;
    logic [DATA_WIDTH-1:0]   data;
    logic                    ack;
    logic                    error;

    modport master (
        output addr, bytesel, wr_en, wr_val, access,
        input  data, ack, error
    );

    modport slave (
        input  addr, bytesel, wr_en, wr_val, access,
        output data, ack, error
    );
endinterface

// File: rtl/oldland_bus_arbiter.sv
// Two-master round-robin arbiter for the oldland data bus with a registered slave request.
// Optional slave timeout is enabled by defining OLDLAND_ARB_TIMEOUT_EN.
module oldland_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    oldland_bus_arbiter_if.slave m0,
    oldland_bus_arbiter_if.slave m1,
    oldland_bus_arbiter_if.master s
);
    // state | meaning
    // IDLE  | no transfer in flight; arbitrate and register the winner's request
    // GNT0  | m0 owns the slave; waiting for s_ack/s_error (or timeout)
    // GNT1  | m1 owns the slave; waiting for s_ack/s_error (or timeout)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("oldland_bus_arbiter: TIMEOUT_CYCLES must be >= 2");
    end

    logic [1:0]              state;
    logic                    last_gnt;
    logic [ADDR_WIDTH-1:0]   s_addr_q;
    logic [DATA_WIDTH/8-1:0] s_bytesel_q;
    logic                    s_wr_en_q;
    logic [DATA_WIDTH-1:0]   s_wr_val_q;
    logic                    s_access_q;
    logic                    pick_m1;
    logic                    tmo;
    logic                    done;

    // m1 wins when it is the only requester, or on contention when m0 was served last
    assign pick_m1 = m1.access && (!m0.access || !last_gnt);

`ifdef OLDLAND_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    assign tmo = (state != IDLE) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1))
                 && !(s.ack || s.error);

    always_ff @(posedge clk) begin
        if (rst || state == IDLE)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end
`else
    assign tmo = 1'b0;
`endif

    assign done = s.ack || s.error || tmo;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            s_access_q  <= 1'b0;
            s_addr_q    <= '0;
            s_bytesel_q <= '0;
            s_wr_en_q   <= 1'b0;
            s_wr_val_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.access || m1.access) begin
                        s_access_q  <= 1'b1;
                        s_addr_q    <= pick_m1 ? m1.addr    : m0.addr;
                        s_bytesel_q <= pick_m1 ? m1.bytesel : m0.bytesel;
                        s_wr_en_q   <= pick_m1 ? m1.wr_en   : m0.wr_en;
                        s_wr_val_q  <= pick_m1 ? m1.wr_val  : m0.wr_val;
                        state       <= pick_m1 ? GNT1 : GNT0;
                    end
                end
                GNT0, GNT1: begin
                    if (done) begin
                        s_access_q <= 1'b0;
                        last_gnt   <= (state == GNT1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s.addr    = s_addr_q;
    assign s.bytesel = s_bytesel_q;
    assign s.wr_en   = s_wr_en_q;
    assign s.wr_val  = s_wr_val_q;
    assign s.access  = s_access_q;

    // Responses go only to the granted master, and only while it still holds access
    always_comb begin
        m0.data  = '0;
        m0.ack   = 1'b0;
        m0.error = 1'b0;
        m1.data  = '0;
        m1.ack   = 1'b0;
        m1.error = 1'b0;
        if (state == GNT0) begin
            m0.data  = s.data;
            m0.ack   = m0.access && s.ack && !s.error;
            m0.error = m0.access && (s.error || tmo);
        end
        if (state == GNT1) begin
            m1.data  = s.data;
            m1.ack   = m1.access && s.ack && !s.error;
            m1.error = m1.access && (s.error || tmo);
        end
    end
endmodule

// File: tb/tb_oldland_bus_arbiter.sv
// Self-checking bench for oldland_bus_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_oldland_bus_arbiter;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oldland_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
    oldland_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
    oldland_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

    oldland_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .m0 (m0_bus),
        .m1 (m1_bus),
        .s  (s_bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the slave (-1 = nobody), who was served last, and the request it carries
    int          owner = -1;
    int          last_m = 1;
    int          age = 0;
    bit          model_ok = 0;
    logic [31:0] e_addr;
    logic [3:0]  e_bs;
    logic        e_we;
    logic [31:0] e_wv;

    function bit tmo_now();
`ifdef OLDLAND_ARB_TIMEOUT_EN
        return (owner >= 0) && (age == TMO - 1) && !(s_bus.ack || s_bus.error);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            owner = -1; last_m = 1; age = 0; model_ok = 1;
        end else if (owner < 0) begin
            if (m0_bus.access || m1_bus.access) begin
                if (m0_bus.access && m1_bus.access) w = 1 - last_m;
                else w = m0_bus.access ? 0 : 1;
                e_addr = w ? m1_bus.addr    : m0_bus.addr;
                e_bs   = w ? m1_bus.bytesel : m0_bus.bytesel;
                e_we   = w ? m1_bus.wr_en   : m0_bus.wr_en;
                e_wv   = w ? m1_bus.wr_val  : m0_bus.wr_val;
                owner  = w;
                age    = 0;
            end
        end else if (s_bus.ack || s_bus.error || tmo_now()) begin
            last_m = owner;
            owner  = -1;
        end else begin
            age++;
        end
    end

    always @(negedge clk) begin
        logic [31:0] d0, d1;
        if (model_ok) begin
            check("s_access", s_bus.access, owner >= 0);
            if (owner >= 0) begin
                check("s_addr", s_bus.addr, e_addr);
                check("s_bytesel", s_bus.bytesel, e_bs);
                check("s_wr_en", s_bus.wr_en, e_we);
                check("s_wr_val", s_bus.wr_val, e_wv);
            end
            d0 = (owner == 0) ? s_bus.data : 32'h0;
            d1 = (owner == 1) ? s_bus.data : 32'h0;
            check("m0_ack", m0_bus.ack, owner == 0 && m0_bus.access && s_bus.ack && !s_bus.error);
            check("m1_ack", m1_bus.ack, owner == 1 && m1_bus.access && s_bus.ack && !s_bus.error);
            check("m0_error", m0_bus.error, owner == 0 && m0_bus.access && (s_bus.error || tmo_now()));
            check("m1_error", m1_bus.error, owner == 1 && m1_bus.access && (s_bus.error || tmo_now()));
            check("m0_data", m0_bus.data, d0);
            check("m1_data", m1_bus.data, d1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_bus.addr = '0; m0_bus.bytesel = '0; m0_bus.wr_en = 0; m0_bus.wr_val = '0; m0_bus.access = 0;
        m1_bus.addr = '0; m1_bus.bytesel = '0; m1_bus.wr_en = 0; m1_bus.wr_val = '0; m1_bus.access = 0;
        s_bus.data = '0; s_bus.ack = 0; s_bus.error = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (!s_bus.access && n < 50) begin
            tick();
            n++;
        end
        if (!s_bus.access) check("grant_timeout", s_bus.access, 1);
    endtask

    // Answer the slave request lat cycles from now; report which master saw the response
    task automatic respond(input int lat, input logic [31:0] d, input bit err, output int who);
        repeat (lat) tick();
        s_bus.ack = 1; s_bus.error = err; s_bus.data = d;
        #1;
        who = (m0_bus.ack || m0_bus.error) ? 0 : ((m1_bus.ack || m1_bus.error) ? 1 : -1);
        tick();
        s_bus.ack = 0; s_bus.error = 0; s_bus.data = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int who, n, seen;
        clear_inputs();
        do_reset();
        check("rst_s_access", s_bus.access, 0);
        check("rst_s_addr", s_bus.addr, 0);

        // Single m0 read, slave answers 3 cycles after s_access
        m0_bus.addr = 32'h100; m0_bus.bytesel = 4'hF; m0_bus.access = 1;
        check("t1_no_early_access", s_bus.access, 0);
        tick();
        check("t1_access_latency", s_bus.access, 1);
        check("t1_s_addr", s_bus.addr, 32'h100);
        repeat (3) tick();
        s_bus.ack = 1; s_bus.data = 32'hDEADBEEF;
        #1;
        check("t1_m0_ack", m0_bus.ack, 1);
        check("t1_m0_data", m0_bus.data, 32'hDEADBEEF);
        check("t1_m1_ack", m1_bus.ack, 0);
        tick();
        s_bus.ack = 0; s_bus.data = '0; m0_bus.access = 0;
        check("t1_idle_after", s_bus.access, 0);

        // Contention right after reset, both held: grants alternate 0,1,0,1
        do_reset();
        m0_bus.addr = 32'hA0; m0_bus.access = 1;
        m1_bus.addr = 32'hB0; m1_bus.access = 1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(n);
            check($sformatf("t2_grant_latency_%0d", i), n, 1);
            respond(1, 32'h100 + i, 0, who);
            check($sformatf("t2_order_%0d", i), who, i % 2);
            check($sformatf("t2_bubble_%0d", i), s_bus.access, 0);
        end
        m0_bus.access = 0; m1_bus.access = 0;
        tick();

        // m1 write, request held stable until ack
        m1_bus.addr = 32'h2000; m1_bus.bytesel = 4'b0011; m1_bus.wr_en = 1;
        m1_bus.wr_val = 32'h1234; m1_bus.access = 1;
        wait_grant(n);
        check("t3_s_addr", s_bus.addr, 32'h2000);
        check("t3_s_bytesel", s_bus.bytesel, 4'b0011);
        check("t3_s_wr_en", s_bus.wr_en, 1);
        check("t3_s_wr_val", s_bus.wr_val, 32'h1234);
        repeat (3) tick();
        check("t3_s_addr_held", s_bus.addr, 32'h2000);
        respond(0, 32'h0, 0, who);
        check("t3_who", who, 1);
        m1_bus.access = 0; m1_bus.wr_en = 0;
        tick();

        // s_ack and s_error together: error wins
        m0_bus.addr = 32'h40; m0_bus.access = 1;
        wait_grant(n);
        s_bus.ack = 1; s_bus.error = 1;
        #1;
        check("t4_m0_error", m0_bus.error, 1);
        check("t4_m0_ack", m0_bus.ack, 0);
        tick();
        s_bus.ack = 0; s_bus.error = 0; m0_bus.access = 0;
        check("t4_idle_next", s_bus.access, 0);
        tick();

        // Reset while m1 is waiting abandons the transfer; a fresh request is served
        m1_bus.addr = 32'h3000; m1_bus.access = 1;
        wait_grant(n);
        tick(); tick();
        rst = 1;
        tick();
        check("t5_rst_access", s_bus.access, 0);
        check("t5_rst_m1_ack", m1_bus.ack, 0);
        rst = 0; m1_bus.access = 0;
        tick();
        m1_bus.addr = 32'h3004; m1_bus.access = 1;
        wait_grant(n);
        check("t5_fresh_addr", s_bus.addr, 32'h3004);
        respond(2, 32'hCAFE, 0, who);
        check("t5_fresh_who", who, 1);
        m1_bus.access = 0;
        tick();

        // Master drops access mid-grant: transfer completes, response discarded
        m0_bus.addr = 32'h80; m0_bus.access = 1;
        wait_grant(n);
        m0_bus.access = 0;
        tick();
        s_bus.ack = 1; s_bus.data = 32'h55;
        #1;
        check("t6_dropped_ack", m0_bus.ack, 0);
        tick();
        s_bus.ack = 0; s_bus.data = '0;
        check("t6_idle", s_bus.access, 0);

        // Stray s_ack while idle is ignored
        s_bus.ack = 1;
        tick();
        s_bus.ack = 0;
        check("t7_stray_ack", s_bus.access, 0);

        // Slave never answers
        m0_bus.addr = 32'hC0; m0_bus.access = 1;
        wait_grant(n);
`ifdef OLDLAND_ARB_TIMEOUT_EN
        seen = -1;
        for (int g = 1; g <= 12 && seen < 0; g++) begin
            #1;
            if (m0_bus.error) seen = g;
            tick();
        end
        m0_bus.access = 0;
        check("t8_timeout_cycle", seen, TMO);
        check("t8_access_dropped", s_bus.access, 0);
`else
        seen = 0;
        repeat (120) begin
            tick();
            if (s_bus.access) seen++;
        end
        check("t8_still_waiting", seen, 120);
        respond(0, 32'h0, 0, who);
        check("t8_late_who", who, 0);
        m0_bus.access = 0;
`endif
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
